aes_block_serializer: RTL and testbench

- Transmit-side counterpart of the AES engine's input stream sink.
- Accepts complete 128-bit AES blocks from the cipher datapath through a valid/ready handshake.
- Serializes each block into four 32-bit words on an hwpe_stream_intf_stream source, which feeds the output streamer.
- Emits a programmed number of blocks per job and reports completion to the controller.

---
 rtl/aes_block_serializer_if.sv | 17 +
 rtl/aes_block_serializer.sv | 154 +++++++++++++++
 tb/tb_aes_block_serializer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_serializer_if.sv
// hwpe_stream_intf_stream: minimal valid/ready word stream used between the
// AES engine and the streamers.
//   data  : DATA_WIDTH-bit payload
//   strb  : byte strobes, one per data byte
//   valid : source has a word
//   ready : sink accepts the word (handshake when valid & ready)
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_block_serializer.sv
// aes_block_serializer: takes 128-bit AES blocks from the cipher datapath and
// emits each as four 32-bit words (word 0 = bits [31:0]) on a stream source.
// A job emits nblocks_i blocks, then pulses done_o.
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         synchronous abort back to IDLE
//   enable_i        start pulse (IDLE only), nblocks_i sampled with it
//   blk_valid_i/blk_data_i/blk_ready_o   block input handshake
//   d_o             word stream source (data, strb, valid, ready)
//   busy_o, done_o, blk_cnt_o            job status
//
// Build option: define AES_SER_PREFETCH_EN to accept the next block on the
// last-word handshake, giving gapless 4-cycle-per-block output.
//
// state | meaning
// IDLE  | waiting for enable_i
// WAIT  | blk_ready_o high, waiting for a block
// SEND  | presenting word[idx] of the registered block
// DONE  | one-cycle done_o pulse, then IDLE
module aes_block_serializer #(
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [CNT_W-1:0]     nblocks_i,
  input  logic                 blk_valid_i,
  input  logic [BLK_W-1:0]     blk_data_i,
  output logic                 blk_ready_o,
  hwpe_stream_intf_stream.source d_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     blk_cnt_o
);

  localparam int unsigned NWORDS = BLK_W / WORD_W;
  localparam int unsigned IDX_W  = $clog2(NWORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_e;

  state_e            state_q;
  logic [BLK_W-1:0]  blk_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  blk_cnt_q;
  logic [CNT_W-1:0]  nblk_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  cnt_inc;
  logic              last_word;

  assign cnt_inc   = blk_cnt_q + CNT_W'(1);
  assign last_word = (state_q == S_SEND) && (idx_q == IDX_W'(NWORDS - 1));

`ifdef AES_SER_PREFETCH_EN
  // Open the input early only when this handshake completes a block and the
  // job still needs more, so a block is never taken that would not be sent.
  assign blk_ready_o = ready_q | (last_word & d_o.ready & (cnt_inc != nblk_q));
`else
  assign blk_ready_o = ready_q;
`endif

  assign d_o.valid = valid_q;
  assign d_o.data  = blk_q[idx_q*WORD_W +: WORD_W];
  assign d_o.strb  = '1;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign blk_cnt_o = blk_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      blk_q     <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      nblk_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            busy_q    <= 1'b1;
            blk_cnt_q <= '0;
            if (nblocks_i != '0) begin
              nblk_q  <= nblocks_i;
              ready_q <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (blk_valid_i) begin
            blk_q   <= blk_data_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (d_o.ready) begin
            idx_q <= idx_q + IDX_W'(1);
            if (last_word) begin
              blk_cnt_q <= cnt_inc;
              if (cnt_inc == nblk_q) begin
                valid_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
`ifdef AES_SER_PREFETCH_EN
              else if (blk_valid_i) begin
                blk_q <= blk_data_i;
                idx_q <= '0;
              end
`endif
              else begin
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                state_q <= S_WAIT;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
module tb_aes_block_serializer;

`ifdef AES_SER_PREFETCH_EN
  localparam int EXP_SPAN3 = 13;
`else
  localparam int EXP_SPAN3 = 15;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic [15:0]  nblocks;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic         busy;
  logic         done;
  logic [15:0]  blk_cnt;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();

  aes_block_serializer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .enable_i    (enable),
    .nblocks_i   (nblocks),
    .blk_valid_i (blk_valid),
    .blk_data_i  (blk_data),
    .blk_ready_o (blk_ready),
    .d_o         (d_if),
    .busy_o      (busy),
    .done_o      (done),
    .blk_cnt_o   (blk_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int cyc = 0;
  int done_cnt, word_cnt, valid_cnt, first_accept, first_word, last_word;

  // Monitor / scoreboard: samples on the falling edge, i.e. what the next
  // rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (d_if.valid) valid_cnt++;
      if (blk_valid && blk_ready && first_accept < 0) first_accept = cyc;
      if (d_if.valid && d_if.ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected: got %08h, required no word", d_if.data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (d_if.data !== e) begin
            n_fail++;
            $display("FAIL word_data: got %08h, required %08h", d_if.data, e);
          end
        end
        if (first_word < 0) first_word = cyc;
        last_word = cyc;
        word_cnt++;
      end
    end
    cyc++;
  end

  task automatic clr_stats();
    done_cnt = 0; word_cnt = 0; valid_cnt = 0;
    first_accept = -1; first_word = -1; last_word = -1;
  endtask

  task automatic start(input int n);
    nblocks = 16'(n);
    enable  = 1'b1;
    @(posedge clk); #1;
    enable  = 1'b0;
  endtask

  // Present one block, push its words as expected output, wait for accept.
  task automatic feed(input logic [127:0] b, input bit keep);
    int k;
    blk_data  = b;
    blk_valid = 1'b1;
    for (int w = 0; w < 4; w++) exp_q.push_back(b[32*w +: 32]);
    k = 0;
    @(negedge clk);
    while (!blk_ready && k < 100) begin @(negedge clk); k++; end
    n_tests++;
    if (!blk_ready) begin
      n_fail++;
      $display("FAIL feed_accept: blk_ready=%0b after %0d cycles, required 1", blk_ready, k);
    end
    @(posedge clk); #1;
    if (!keep) blk_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 300) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt);
    end
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (d_if.valid !== 1'b0 || blk_ready !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_immediate: valid=%0b ready=%0b busy=%0b cnt=%0d done=%0b, required all 0",
               d_if.valid, blk_ready, busy, blk_cnt, done);
    end
    n_tests++;
    if (d_if.data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %08h, required 0", d_if.data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (d_if.valid !== 1'b0 || blk_ready !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: valid=%0b ready=%0b busy=%0b cnt=%0d, required all 0",
                 i, d_if.valid, blk_ready, busy, blk_cnt);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || d_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%0b valid=%0b, required 0 0", busy, d_if.valid);
    end
  endtask

  task automatic test_single();
    clr_stats();
    start(1);
    n_tests++;
    if (busy !== 1'b1 || blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait: busy=%0b ready=%0b, required 1 1", busy, blk_ready);
    end
    feed(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    n_tests++;
    if (d_if.strb !== 4'hF) begin
      n_fail++;
      $display("FAIL strb: got %h, required f", d_if.strb);
    end
    wait_done("single");
    n_tests++;
    if (first_word - first_accept != 1 || last_word - first_word != 3) begin
      n_fail++;
      $display("FAIL single_latency: first=%0d last=%0d, required 1 3",
               first_word - first_accept, last_word - first_word);
    end
    n_tests++;
    if (word_cnt != 4 || blk_cnt !== 16'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_count: words=%0d cnt=%0d left=%0d, required 4 1 0",
               word_cnt, blk_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int stall = 0;
    clr_stats();
    start(1);
    feed(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (word_cnt == 2 && stall < 3) begin
        d_if.ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (d_if.valid !== 1'b1 || d_if.data !== 32'h44556677) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: valid=%0b data=%08h, required 1 44556677",
                   stall, d_if.valid, d_if.data);
        end
        stall++;
      end else begin
        d_if.ready = 1'b1;
      end
    end
    d_if.ready = 1'b1;
    wait_done("bp");
    n_tests++;
    if (word_cnt != 4 || exp_q.size() != 0 || stall != 3) begin
      n_fail++;
      $display("FAIL bp_words: words=%0d left=%0d stalls=%0d, required 4 0 3",
               word_cnt, exp_q.size(), stall);
    end
  endtask

  task automatic test_multi();
    clr_stats();
    start(3);
    feed(rnd_blk(), 1'b1);
    feed(rnd_blk(), 1'b1);
    feed(rnd_blk(), 1'b0);
    wait_done("multi");
    n_tests++;
    if (word_cnt != 12 || valid_cnt != 12 || blk_cnt !== 16'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL multi_count: words=%0d valid_cycles=%0d cnt=%0d left=%0d, required 12 12 3 0",
               word_cnt, valid_cnt, blk_cnt, exp_q.size());
    end
    // Inclusive cycle count from the accept cycle of block 0 to the last word.
    n_tests++;
    if (last_word - first_accept + 1 != EXP_SPAN3) begin
      n_fail++;
      $display("FAIL multi_span: got %0d cycles, required %0d",
               last_word - first_accept + 1, EXP_SPAN3);
    end
  endtask

  task automatic test_zero();
    clr_stats();
    start(0);
    wait_done("zero");
    n_tests++;
    if (valid_cnt != 0 || word_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_traffic: valid_cycles=%0d words=%0d busy=%0b, required 0 0 0",
               valid_cnt, word_cnt, busy);
    end
  endtask

  task automatic test_clear();
    int k = 0;
    clr_stats();
    start(4);
    feed(rnd_blk(), 1'b1);
    feed(rnd_blk(), 1'b0);
    while (word_cnt != 5 && k < 50) begin @(posedge clk); #1; k++; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || d_if.valid !== 1'b0 || blk_ready !== 1'b0 || blk_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_state: busy=%0b valid=%0b ready=%0b cnt=%0d, required 0 0 0 0",
               busy, d_if.valid, blk_ready, blk_cnt);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (done_cnt != 0 || word_cnt != 6) begin
      n_fail++;
      $display("FAIL clear_nodone: done=%0d words=%0d, required 0 6", done_cnt, word_cnt);
    end
    clr_stats();
    start(2);
    feed(rnd_blk(), 1'b1);
    feed(rnd_blk(), 1'b0);
    wait_done("after_clear");
    n_tests++;
    if (word_cnt != 8 || blk_cnt !== 16'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_clear_count: words=%0d cnt=%0d left=%0d, required 8 2 0",
               word_cnt, blk_cnt, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    clr_stats();
    start(2);
    feed(rnd_blk(), 1'b0);
    nblocks = 16'd7;
    enable  = 1'b1;
    @(posedge clk); #1;
    enable  = 1'b0;
    feed(rnd_blk(), 1'b0);
    wait_done("ignored");
    repeat (20) @(negedge clk);
    n_tests++;
    if (done_cnt != 1 || word_cnt != 8 || blk_cnt !== 16'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_job: done=%0d words=%0d cnt=%0d busy=%0b, required 1 8 2 0",
               done_cnt, word_cnt, blk_cnt, busy);
    end
  endtask

  task automatic test_async_reset_midjob();
    clr_stats();
    start(2);
    feed(rnd_blk(), 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (d_if.valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b0 || blk_cnt !== 16'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midjob_reset: valid=%0b busy=%0b ready=%0b cnt=%0d done=%0b, required all 0",
               d_if.valid, busy, blk_ready, blk_cnt, done);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (done_cnt != 0 || d_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midjob_reset_quiet: done=%0d valid=%0b, required 0 0", done_cnt, d_if.valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; nblocks = '0;
    blk_valid = 1'b0; blk_data = '0; d_if.ready = 1'b1;
    clr_stats();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_multi();
    test_zero();
    test_clear();
    test_start_ignored();
    test_async_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
